bit_destuff_monitor: RTL and testbench

Parametrised successor to the single-threshold CAN stuff-error detector. Resolves each bit from 1 or MAX_SAMPLES majority-voted samples, tracks run length, and removes stuff bits. It separates data bits from stuff bits and flags stuff errors with a sticky flag and a saturating error counter. Sits between the bit-timing/sample-point logic and the frame decoder in the CAN receive path.

---
 rtl/bit_destuff_monitor.sv | 107 ++++++++++
 tb/tb_bit_destuff_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bit_destuff_monitor.sv
// CAN receive-path bit resolver: majority-votes samples into bits, strips stuff bits
// and flags stuff errors with a sticky flag plus a saturating counter.
module bit_destuff_monitor #(
   parameter int STUFF_LEN   = 5,
   parameter int MAX_SAMPLES = 3,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                               clk,
   input  logic                               resetN,
   input  logic                               dIn,
   input  logic                               samplePulse,
   input  logic                               rateSelector,
   input  logic                               bitBoundary,
   input  logic                               stuffEn,
   input  logic                               errClear,
   output logic                               bitOut,
   output logic                               bitValid,
   output logic                               stuffBit,
   output logic                               errorFrame,
   output logic [ERR_CNT_W-1:0]               errCount,
   output logic [$clog2(STUFF_LEN+1)-1:0]     runLen
);

   localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
   localparam int RUN_W = $clog2(STUFF_LEN + 1);

   logic [CNT_W-1:0]     samp_cnt, ones_cnt, tgt;
   logic [CNT_W-1:0]     cnt_base, ones_base, tgt_eff, cnt_nxt, ones_nxt;
   logic                 accept, resolve, b, last_bit;
   logic                 last_n, bitout_n, valid_n, stuff_n, err_n, is_err;
   logic [RUN_W-1:0]     run_n;
   logic [ERR_CNT_W-1:0] err_base, cnt_n;

   // A boundary coincident with a sample is applied first, so the sample opens the new bit.
   always_comb begin
      cnt_base  = bitBoundary ? '0 : samp_cnt;
      ones_base = bitBoundary ? '0 : ones_cnt;
      tgt_eff   = (cnt_base == '0) ? (rateSelector ? CNT_W'(MAX_SAMPLES) : CNT_W'(1)) : tgt;
      accept    = samplePulse && (cnt_base < tgt_eff);
      cnt_nxt   = cnt_base + CNT_W'(accept);
      ones_nxt  = ones_base + CNT_W'(accept & dIn);
      resolve   = accept && (cnt_nxt == tgt_eff);
      b         = ones_nxt > (tgt_eff >> 1);
   end

   always_comb begin
      last_n   = last_bit;
      bitout_n = bitOut;
      run_n    = stuffEn ? runLen : '0;
      valid_n  = 1'b0;
      stuff_n  = 1'b0;
      is_err   = 1'b0;
      err_base = errClear ? '0 : errCount;
      err_n    = errClear ? 1'b0 : errorFrame;
      if (resolve) begin
         bitout_n = b;
         last_n   = b;
         if (!stuffEn) begin
            valid_n = 1'b1;
            run_n   = '0;
         end else if (runLen == RUN_W'(STUFF_LEN)) begin
            run_n = RUN_W'(1);
            if (b != last_bit) stuff_n = 1'b1;
            else               is_err  = 1'b1;
         end else if (runLen != '0 && b == last_bit) begin
            run_n   = runLen + RUN_W'(1);
            valid_n = 1'b1;
         end else begin
            run_n   = RUN_W'(1);
            valid_n = 1'b1;
         end
      end
      // A new error outranks a coincident clear: count restarts from the cleared value.
      cnt_n = err_base;
      if (is_err) begin
         err_n = 1'b1;
         if (!(&err_base)) cnt_n = err_base + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         samp_cnt   <= '0;
         ones_cnt   <= '0;
         tgt        <= '0;
         last_bit   <= 1'b0;
         bitOut     <= 1'b0;
         bitValid   <= 1'b0;
         stuffBit   <= 1'b0;
         errorFrame <= 1'b0;
         errCount   <= '0;
         runLen     <= '0;
      end else begin
         samp_cnt   <= cnt_nxt;
         ones_cnt   <= ones_nxt;
         tgt        <= tgt_eff;
         last_bit   <= last_n;
         bitOut     <= bitout_n;
         bitValid   <= valid_n;
         stuffBit   <= stuff_n;
         errorFrame <= err_n;
         errCount   <= cnt_n;
         runLen     <= run_n;
      end
   end

endmodule

// File: tb/tb_bit_destuff_monitor.sv
// Randomized and directed bench for bit_destuff_monitor against a queue-based reference model.
module tb_bit_destuff_monitor;

   localparam int SL   = 5;
   localparam int MS   = 3;
   localparam int ECW  = 2;
   localparam int CMAX = (1 << ECW) - 1;

   logic           clk = 1'b0;
   logic           resetN, dIn, samplePulse, rateSelector, bitBoundary, stuffEn, errClear;
   logic           bitOut, bitValid, stuffBit, errorFrame;
   logic [ECW-1:0] errCount;
   logic [2:0]     runLen;

   bit_destuff_monitor #(.STUFF_LEN(SL), .MAX_SAMPLES(MS), .ERR_CNT_W(ECW)) dut (
      .clk(clk), .resetN(resetN), .dIn(dIn), .samplePulse(samplePulse),
      .rateSelector(rateSelector), .bitBoundary(bitBoundary), .stuffEn(stuffEn),
      .errClear(errClear), .bitOut(bitOut), .bitValid(bitValid), .stuffBit(stuffBit),
      .errorFrame(errorFrame), .errCount(errCount), .runLen(runLen));

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;
   bit rs = 0, se = 1;

   // Reference model: samples of the bit in progress, and the bits of the current run.
   bit samp_q[$];
   bit run_q[$];
   int m_tgt = 1;
   bit m_bitout = 0, e_valid = 0, e_stuff = 0, m_err = 0;
   int m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".bitOut"},     32'(bitOut),     32'(m_bitout));
      chk({tag, ".bitValid"},   32'(bitValid),   32'(e_valid));
      chk({tag, ".stuffBit"},   32'(stuffBit),   32'(e_stuff));
      chk({tag, ".errorFrame"}, 32'(errorFrame), 32'(m_err));
      chk({tag, ".errCount"},   32'(errCount),   32'(m_cnt));
      chk({tag, ".runLen"},     32'(runLen),     32'(run_q.size()));
   endtask

   task automatic model_reset();
      samp_q.delete(); run_q.delete();
      m_bitout = 0; e_valid = 0; e_stuff = 0; m_err = 0; m_cnt = 0; m_tgt = 1;
   endtask

   task automatic model_update(input bit pulse, input bit d, input bit bnd, input bit clr);
      int ones;
      bit b;
      e_valid = 0; e_stuff = 0;
      if (clr) begin m_err = 0; m_cnt = 0; end
      if (bnd) samp_q.delete();
      if (!se) run_q.delete();
      if (pulse) begin
         if (samp_q.size() == 0) m_tgt = rs ? MS : 1;
         if (samp_q.size() < m_tgt) begin
            samp_q.push_back(d);
            if (samp_q.size() == m_tgt) begin
               ones = 0;
               foreach (samp_q[i]) ones += int'(samp_q[i]);
               b = (2 * ones > m_tgt);
               m_bitout = b;
               if (!se) e_valid = 1;
               else if (run_q.size() == SL) begin
                  if (b != run_q[0]) e_stuff = 1;
                  else begin
                     m_err = 1;
                     m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
                  end
                  run_q.delete(); run_q.push_back(b);
               end else if (run_q.size() > 0 && b == run_q[0]) begin
                  run_q.push_back(b); e_valid = 1;
               end else begin
                  run_q.delete(); run_q.push_back(b); e_valid = 1;
               end
            end
         end
      end
   endtask

   // One driven cycle followed by one quiet cycle, checked after each edge.
   task automatic step(input bit pulse, input bit d, input bit bnd, input bit clr, input string tag);
      @(negedge clk);
      samplePulse = pulse; dIn = d; bitBoundary = bnd; errClear = clr;
      rateSelector = rs; stuffEn = se;
      model_update(pulse, d, bnd, clr);
      @(posedge clk); #1;
      check_all(tag);
      @(negedge clk);
      samplePulse = 0; bitBoundary = 0; errClear = 0;
      e_valid = 0; e_stuff = 0;
      @(posedge clk); #1;
      check_all({tag, ".idle"});
   endtask

   task automatic bit1(input bit d, input bit clr, input string tag);
      step(1, d, 1, clr, tag);
   endtask

   task automatic bit3(input bit s0, input bit s1, input bit s2, input string tag);
      step(1, s0, 1, 0, tag);
      step(1, s1, 0, 0, tag);
      step(1, s2, 0, 0, tag);
   endtask

   initial begin
      resetN = 0; dIn = 0; samplePulse = 0; rateSelector = 0; bitBoundary = 0;
      stuffEn = 1; errClear = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk) resetN = 1;

      // Stuff bit after five ones
      rs = 0; se = 1;
      for (int i = 0; i < 5; i++) bit1(1, 0, "run1");
      bit1(0, 0, "stuff");

      // Six ones then ten zeros: two stuff errors
      for (int i = 0; i < 6; i++) bit1(1, 0, "err1");
      for (int i = 0; i < 10; i++) bit1(0, 0, "zeros");

      // Majority vote, extra pulse ignored
      rs = 1;
      bit3(1, 0, 1, "vote101");
      bit3(0, 0, 1, "vote001");
      step(1, 1, 0, 0, "extra");

      // Pass-through then stuffing re-enabled
      rs = 0; se = 0;
      for (int i = 0; i < 8; i++) bit1(1, 0, "pass");
      se = 1;
      for (int i = 0; i < 6; i++) bit1(1, 0, "reen");

      // Saturation, clear, clear coincident with an error
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 5; i++) bit1(1, 0, "sat");
      end
      step(0, 0, 0, 1, "clear");
      for (int i = 0; i < 4; i++) bit1(1, 0, "preclr");
      bit1(1, 1, "clr_err");

      // Reset mid-bit discards partial samples
      rs = 1;
      step(1, 1, 1, 0, "part");
      step(1, 1, 0, 0, "part");
      #2 resetN = 0;
      model_reset();
      #1 check_all("rst_async");
      @(negedge clk) resetN = 1;
      step(1, 1, 0, 0, "fresh");
      step(1, 1, 0, 0, "fresh");
      step(1, 0, 0, 0, "fresh");

      // Randomized traffic with long runs
      begin
         bit d = 1;
         for (int n = 0; n < 300; n++) begin
            bit clr, r0;
            int ns;
            if ($urandom_range(7) == 0) se = ~se;
            rs = 1'($urandom_range(1));
            r0 = rs;
            ns = r0 ? MS : 1;
            if ($urandom_range(4) == 0) d = ~d;
            clr = ($urandom_range(15) == 0);
            if ($urandom_range(3) == 0) step(0, 0, 1, 0, "rnd.bnd");
            for (int s = 0; s < ns; s++) begin
               bit sv;
               sv = ($urandom_range(5) == 0) ? ~d : d;
               step(1, sv, (s == 0), (s == ns - 1) && clr, "rnd");
               if ($urandom_range(3) == 0) rs = ~rs;
            end
            if ($urandom_range(5) == 0) step(1, ~d, 0, 0, "rnd.extra");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
